// File: rtl/updown_ctrl_pkg.sv
// Shared types and defaults for the supervised up/down counter sequencer.
//   ctrl_state_t : sequencer FSM states
//   DEF_WIDTH    : default counter/bound width
package updown_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/updown_counter_core.sv
// WIDTH-bit synchronous up/down counter owned by the sequencer datapath.
// Ports:
//   clk      : rising-edge clock
//   clr      : synchronous active-high reset (q -> 0)
//   load     : load load_val (wins over en)
//   load_val : value to load
//   en       : step by one in the direction given by up
//   up       : 1 = increment, 0 = decrement
//   q        : current count
module updown_counter_core
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: load has priority over stepping.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/updown_count_ctrl.sv
// Sequencer that steps a WIDTH-bit counter between a captured low and high
// bound at a prescaled rate and reports completion.
// Optional feature macro: PINGPONG_EN (bounce between bounds forever instead
// of a single pass; only abort or clr end the sequence).
// Ports:
//   clk, clr          : clock and synchronous active-high reset
//   start             : begin a sequence (IDLE only)
//   cfg_lo/hi/dir     : bounds and direction captured on an accepted start
//   pause             : freeze count and prescaler while high
//   abort             : return to IDLE without a done pulse
//   count, dir        : current count and direction
//   busy              : in RUN or HOLD
//   done              : one-cycle completion pulse (DONE state)
//   tc                : count sits at the terminal bound
//   err               : one-cycle pulse for a start with cfg_lo > cfg_hi
module updown_count_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic             cfg_dir,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             err
);

    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    ctrl_state_t      state_q, state_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] step_val;
    logic             tick;

    assign end_val  = dir_q ? lo_q : hi_q;
    assign step_val = dir_q ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
    assign tick     = (psc_q == PSC_LAST);

    // Next-state, bound capture and counter control.
    always_comb begin
        state_d      = state_q;
        psc_d        = psc_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        dir_d        = dir_q;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = cnt;
        cnt_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_lo > cfg_hi) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d         = cfg_lo;
                        hi_d         = cfg_hi;
                        dir_d        = cfg_dir;
                        cnt_load     = 1'b1;
                        cnt_load_val = cfg_dir ? cfg_hi : cfg_lo;
                        psc_d        = '0;
`ifdef PINGPONG_EN
                        state_d      = RUN;
`else
                        state_d      = (cfg_lo == cfg_hi) ? DONE : RUN;
`endif
                    end
                end
            end

            // HOLD with pause released behaves like RUN on the same edge, so
            // the sequence is delayed by exactly the cycles pause was high.
            RUN, HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    if (tick) begin
                        psc_d = '0;
`ifdef PINGPONG_EN
                        // Degenerate lo==hi range parks the count at the bound.
                        if (lo_q != hi_q) begin
                            cnt_en = 1'b1;
                            if (step_val == end_val) begin
                                dir_d = ~dir_q;
                            end
                        end
`else
                        cnt_en = 1'b1;
                        if (step_val == end_val) begin
                            state_d = DONE;
                        end
`endif
                    end else begin
                        psc_d = psc_q + PSC_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            psc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    updown_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (~dir_q),
        .q        (cnt)
    );

    // Status outputs decoded from registered state.
    assign count = cnt;
    assign dir   = dir_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);
    assign err   = err_q;
`ifdef PINGPONG_EN
    assign tc    = busy && ((cnt == lo_q) || (cnt == hi_q));
`else
    assign tc    = (state_q != IDLE) && (cnt == end_val);
`endif

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Scoreboard bench: two instances (PRESCALE 1 and 3) share stimulus; a
// sequence-level reference model predicts every cycle's outputs into queues
// that a separate monitor drains and compares.
module tb_updown_count_ctrl;

`ifdef PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef struct {
        logic [3:0] count;
        logic       dir;
        logic       busy;
        logic       done;
        logic       tc;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cfg_lo = '0;
    logic [3:0] cfg_hi = '0;
    logic       cfg_dir = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;

    logic [3:0] count_a, count_b;
    logic       dir_a, busy_a, done_a, tc_a, err_a;
    logic       dir_b, busy_b, done_b, tc_b, err_b;

    int errors = 0;
    int checks = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
    int m_cnt[2], m_dir[2], m_lo[2], m_hi[2], m_phase[2];
    bit m_active[2], m_fin[2], m_err[2];
    int psc_of[2] = '{1, 3};

    always #5 clk = ~clk;

    updown_count_ctrl #(.WIDTH(4), .PRESCALE(1)) u_dut_a (
        .clk(clk), .clr(clr), .start(start), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .cfg_dir(cfg_dir), .pause(pause), .abort(abort),
        .count(count_a), .dir(dir_a), .busy(busy_a), .done(done_a), .tc(tc_a), .err(err_a)
    );

    updown_count_ctrl #(.WIDTH(4), .PRESCALE(3)) u_dut_b (
        .clk(clk), .clr(clr), .start(start), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .cfg_dir(cfg_dir), .pause(pause), .abort(abort),
        .count(count_b), .dir(dir_b), .busy(busy_b), .done(done_b), .tc(tc_b), .err(err_b)
    );

    // Advance the sequence model by one clock edge and return the outputs
    // visible after that edge.
    function automatic exp_t model_step(int i, bit c, bit st, int lo, int hi, bit d, bit ps, bit ab);
        exp_t e;
        int   endb;
        m_err[i] = 1'b0;
        if (c) begin
            m_cnt[i] = 0; m_dir[i] = 0; m_lo[i] = 0; m_hi[i] = 0; m_phase[i] = 0;
            m_active[i] = 1'b0; m_fin[i] = 1'b0;
        end else if (ab && (m_active[i] || m_fin[i])) begin
            m_active[i] = 1'b0; m_fin[i] = 1'b0;
        end else if (m_fin[i]) begin
            m_fin[i] = 1'b0;
        end else if (!m_active[i]) begin
            if (st) begin
                if (lo > hi) begin
                    m_err[i] = 1'b1;
                end else begin
                    m_lo[i] = lo; m_hi[i] = hi; m_dir[i] = int'(d);
                    m_cnt[i] = d ? hi : lo;
                    m_phase[i] = 0;
                    if (lo == hi && !PP) m_fin[i] = 1'b1;
                    else m_active[i] = 1'b1;
                end
            end
        end else if (!ps) begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == psc_of[i]) begin
                m_phase[i] = 0;
                if (!(PP && m_lo[i] == m_hi[i])) begin
                    m_cnt[i] = (m_dir[i] != 0) ? m_cnt[i] - 1 : m_cnt[i] + 1;
                    endb = (m_dir[i] != 0) ? m_lo[i] : m_hi[i];
                    if (m_cnt[i] == endb) begin
                        if (PP) begin
                            m_dir[i] = 1 - m_dir[i];
                        end else begin
                            m_active[i] = 1'b0;
                            m_fin[i] = 1'b1;
                        end
                    end
                end
            end
        end
        endb = (m_dir[i] != 0) ? m_lo[i] : m_hi[i];
        e.count = 4'(m_cnt[i]);
        e.dir   = (m_dir[i] != 0);
        e.busy  = m_active[i];
        e.done  = m_fin[i];
        e.err   = m_err[i];
        if (PP) e.tc = m_active[i] && (m_cnt[i] == m_lo[i] || m_cnt[i] == m_hi[i]);
        else    e.tc = (m_active[i] || m_fin[i]) && (m_cnt[i] == endb);
        return e;
    endfunction

    // Apply one cycle of inputs (away from the active edge) and predict it.
    task automatic drive(bit c, bit st, int lo, int hi, bit d, bit ps, bit ab);
        @(negedge clk);
        clr = c; start = st; cfg_lo = 4'(lo); cfg_hi = 4'(hi);
        cfg_dir = d; pause = ps; abort = ab;
        q_a.push_back(model_step(0, c, st, lo, hi, d, ps, ab));
        q_b.push_back(model_step(1, c, st, lo, hi, d, ps, ab));
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom), 1'b0, 1'b0);
    endtask

    task automatic go(int lo, int hi, bit d);
        drive(1'b0, 1'b1, lo, hi, d, 1'b0, 1'b0);
    endtask

    function automatic void cmp(string nm, string inst, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%s] got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endfunction

    // Monitor: pops one prediction per instance after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("count", "P1", count_a, e.count);
                cmp("dir",   "P1", 4'(dir_a),  4'(e.dir));
                cmp("busy",  "P1", 4'(busy_a), 4'(e.busy));
                cmp("done",  "P1", 4'(done_a), 4'(e.done));
                cmp("tc",    "P1", 4'(tc_a),   4'(e.tc));
                cmp("err",   "P1", 4'(err_a),  4'(e.err));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("count", "P3", count_b, e.count);
                cmp("dir",   "P3", 4'(dir_b),  4'(e.dir));
                cmp("busy",  "P3", 4'(busy_b), 4'(e.busy));
                cmp("done",  "P3", 4'(done_b), 4'(e.done));
                cmp("tc",    "P3", 4'(tc_b),   4'(e.tc));
                cmp("err",   "P3", 4'(err_b),  4'(e.err));
            end
        end
    end

    initial begin
        // Reset
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Up 3..6
        go(3, 6, 1'b0);  idle(20);
        // Down 9..2
        go(2, 9, 1'b1);  idle(30);
        // Pause mid-sequence, then resume
        go(0, 7, 1'b0);  idle(3);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(30);
        // Abort then immediate restart
        go(0, 9, 1'b0);  idle(4);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        go(1, 3, 1'b0);  idle(15);
        // Rejected start, degenerate range, clear mid-run
        go(7, 4, 1'b0);  idle(2);
        go(5, 5, 1'b0);  idle(3);
        go(0, 15, 1'b0); idle(5);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Full range, abort ends it
        go(0, 15, 1'b0); idle(40);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 399) == 0),
                  1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 79) == 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
